// File: rtl/display_decoder_if.sv
// display_decoder_if: board-level seven-segment display bus as seen by the
// receive-side decoder.
//   anode[3:0]    digit strobes, active low (1110 = digit0 ... 0111 = digit3)
//   cathode[7:0]  segments, active low, bit order pGFEDCBA
//   digit0..3     last decoded value per digit
//   valid[3:0]    per-digit good-decode flags
//   frame_done    one-cycle pulse on a complete in-order frame
//   decode_error  one-cycle pulse on an illegal anode/cathode sample
// master = whoever drives the display bus; slave = the decoder.
interface display_decoder_if;
  logic [3:0] anode;
  logic [7:0] cathode;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] valid;
  logic       frame_done;
  logic       decode_error;

  modport master (
    output anode, cathode,
    input  digit0, digit1, digit2, digit3, valid, frame_done, decode_error
  );

  modport slave (
    input  anode, cathode,
    output digit0, digit1, digit2, digit3, valid, frame_done, decode_error
  );
endinterface

// File: rtl/display_decoder.sv
// display_decoder: samples the multiplexed active-low seven-segment bus,
// waits for each strobed digit to settle, and decodes the cathode pattern
// back to a 4-bit value per digit.
//   clk    single clock, rising edge
//   rst_n  asynchronous, active-low reset
//   bus    display_decoder_if.slave (anode/cathode in; digits, valid,
//          frame_done, decode_error out -- all registered)
// Parameters: SETTLE_CYCLES (2..255) stable cycles before sampling;
// TIMEOUT cycles without a good decode before all digits are invalidated.
module display_decoder #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic [31:0] TIMEOUT       = 32'd500000
) (
  input  logic               clk,
  input  logic               rst_n,
  display_decoder_if.slave   bus
);

  typedef enum logic [1:0] {HUNT, GOT0, GOT1, GOT2} state_t;

  localparam logic [7:0]  SETTLE_MAX   = 8'(SETTLE_CYCLES);
  localparam logic [7:0]  SAMPLE_AT    = 8'(SETTLE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT - 32'd1;

  // Returns {legal, value}; segments are active low, A in bit 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h40:   seg_decode = {1'b1, 4'd0};
      7'h79:   seg_decode = {1'b1, 4'd1};
      7'h24:   seg_decode = {1'b1, 4'd2};
      7'h30:   seg_decode = {1'b1, 4'd3};
      7'h19:   seg_decode = {1'b1, 4'd4};
      7'h12:   seg_decode = {1'b1, 4'd5};
      7'h02:   seg_decode = {1'b1, 4'd6};
      7'h78:   seg_decode = {1'b1, 4'd7};
      7'h00:   seg_decode = {1'b1, 4'd8};
      7'h18:   seg_decode = {1'b1, 4'd9};
      default: seg_decode = {1'b0, 4'd0};
    endcase
  endfunction

  // Returns {one_hot_low, blank, digit index}.
  function automatic logic [3:0] anode_decode(input logic [3:0] a);
    case (a)
      4'b1110: anode_decode = 4'b10_00;
      4'b1101: anode_decode = 4'b10_01;
      4'b1011: anode_decode = 4'b10_10;
      4'b0111: anode_decode = 4'b10_11;
      4'b1111: anode_decode = 4'b01_00;
      default: anode_decode = 4'b00_00;
    endcase
  endfunction

  logic [11:0]      sync_p0, s_bus_p1, prev_p2;
  logic [7:0]       cnt_q;
  logic [31:0]      tcnt_q;
  state_t           state_q, state_d, restart_state;
  logic [3:0][3:0]  digit_q;
  logic [3:0]       valid_q;
  logic             frame_done_q, decode_error_q;

  logic             sample, a_one_hot, a_blank, c_legal;
  logic [1:0]       a_idx;
  logic [3:0]       c_val, sel_mask;
  logic             good, bad_cath, bad_anode, timeout_hit, frame_hit;

  // Stage 2: stability check and decode of the synchronized bus
  assign sample      = (s_bus_p1 == prev_p2) && (cnt_q == SAMPLE_AT);
  assign {a_one_hot, a_blank, a_idx} = anode_decode(s_bus_p1[11:8]);
  assign {c_legal, c_val}            = seg_decode(s_bus_p1[6:0]);
  assign sel_mask    = 4'b0001 << a_idx;
  assign good        = sample && a_one_hot && c_legal;
  assign bad_cath    = sample && a_one_hot && !c_legal;
  assign bad_anode   = sample && !a_one_hot && !a_blank;
  assign timeout_hit = (tcnt_q == TIMEOUT_LAST);
  // An out-of-order digit restarts the frame only if it is digit0.
  assign restart_state = (a_idx == 2'd0) ? GOT0 : HUNT;

  always_comb begin
    state_d   = state_q;
    frame_hit = 1'b0;
    if (good) begin
      case (state_q)
        HUNT: state_d = restart_state;
        GOT0: state_d = (a_idx == 2'd1) ? GOT1 : restart_state;
        GOT1: state_d = (a_idx == 2'd2) ? GOT2 : restart_state;
        GOT2: begin
          if (a_idx == 2'd3) begin
            state_d   = HUNT;
            frame_hit = 1'b1;
          end else begin
            state_d = restart_state;
          end
        end
        default: state_d = HUNT;
      endcase
    end else if (bad_cath || bad_anode || timeout_hit) begin
      state_d = HUNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0        <= 12'hFFF;
      s_bus_p1       <= 12'hFFF;
      prev_p2        <= 12'hFFF;
      cnt_q          <= '0;
      tcnt_q         <= '0;
      digit_q        <= '0;
      valid_q        <= '0;
      frame_done_q   <= 1'b0;
      decode_error_q <= 1'b0;
    end else begin
      // Stage 0/1: two-flop synchronizer
      sync_p0  <= {bus.anode, bus.cathode};
      s_bus_p1 <= sync_p0;
      // Stage 2: previous-value register and saturating settle counter
      prev_p2  <= s_bus_p1;
      if (s_bus_p1 != prev_p2) begin
        cnt_q <= '0;
      end else if (cnt_q != SETTLE_MAX) begin
        cnt_q <= cnt_q + 8'd1;
      end
      // Stage 3: registered decode results
      frame_done_q   <= frame_hit;
      decode_error_q <= bad_cath || bad_anode;
      if (good) begin
        digit_q[a_idx] <= c_val;
        // A good decode on the timeout cycle wins, but only its digit stays valid.
        valid_q        <= timeout_hit ? sel_mask : (valid_q | sel_mask);
        tcnt_q         <= '0;
      end else begin
        if (timeout_hit) begin
          valid_q <= '0;
          tcnt_q  <= '0;
        end else begin
          tcnt_q <= tcnt_q + 32'd1;
        end
        if (bad_cath) begin
          valid_q[a_idx] <= 1'b0;
        end
      end
    end
  end

  assign bus.digit0       = digit_q[0];
  assign bus.digit1       = digit_q[1];
  assign bus.digit2       = digit_q[2];
  assign bus.digit3       = digit_q[3];
  assign bus.valid        = valid_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.decode_error = decode_error_q;

endmodule

// File: tb/tb_display_decoder.sv
// Bench for display_decoder. The reference model works on the history of
// applied bus patterns: a pattern is sampled when it was applied for exactly
// SETTLE_CYCLES+1 consecutive edges (two edges earlier, through the
// synchronizer) after a different pattern. Timeout is the distance in edges
// from the last good decode; the frame is tracked as "next expected digit".
module tb_display_decoder;
  localparam int S  = 16;
  localparam int TO = 400;

  localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  display_decoder_if dif();

  display_decoder #(.SETTLE_CYCLES(S), .TIMEOUT(32'(TO))) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int fd_seen = 0;
  int de_seen = 0;

  // Reference model state
  logic [11:0] hist[$];
  int          n;
  int          last_clear;
  int          nxt;
  logic [3:0]  exp_digit [4];
  logic [3:0]  exp_valid;
  logic        exp_fd, exp_de;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int seg_val(input logic [6:0] c);
    seg_val = -1;
    for (int i = 0; i < 10; i++) if (SEG[i] == c) seg_val = i;
  endfunction

  function automatic logic [11:0] hget(input int m);
    if (m < 1) return 12'hFFF;
    return hist[m-1];
  endfunction

  function automatic logic [11:0] digit_pat(input int k, input int v);
    logic [3:0] a;
    a = ~(4'(1 << k));
    return {a, 1'($urandom_range(0, 1)), SEG[v]};
  endfunction

  task automatic model_reset();
    hist.delete();
    n = 0; last_clear = 0; nxt = 0;
    for (int i = 0; i < 4; i++) exp_digit[i] = 4'd0;
    exp_valid = 4'd0; exp_fd = 1'b0; exp_de = 1'b0;
  endtask

  task automatic model_edge();
    logic [11:0] p;
    bit smp, tout;
    int k, v;
    n++;
    exp_fd = 1'b0;
    exp_de = 1'b0;
    p   = hget(n - 2);
    smp = (hget(n - S - 3) != p);
    for (int m = n - S - 2; m <= n - 2; m++) if (hget(m) != p) smp = 1'b0;
    tout = ((n - last_clear) == TO);
    k = -1;
    for (int i = 0; i < 4; i++) if (p[11:8] == ~(4'(1 << i))) k = i;
    v = seg_val(p[6:0]);
    if (smp && k >= 0 && v >= 0) begin
      exp_digit[k] = 4'(v);
      exp_valid    = tout ? 4'(1 << k) : (exp_valid | 4'(1 << k));
      last_clear   = n;
      if (k == nxt) begin
        if (k == 3) exp_fd = 1'b1;
        nxt = (k + 1) % 4;
      end else begin
        nxt = (k == 0) ? 1 : 0;
      end
    end else begin
      if (tout) begin
        exp_valid  = 4'd0;
        last_clear = n;
        nxt        = 0;
      end
      if (smp && p[11:8] != 4'hF) begin
        exp_de = 1'b1;
        nxt    = 0;
        if (k >= 0) exp_valid[k] = 1'b0;
      end
    end
  endtask

  // Apply one pattern for one clock edge, advance the model, compare #1 later.
  task automatic tick(input logic [11:0] pat);
    dif.anode   = pat[11:8];
    dif.cathode = pat[7:0];
    @(posedge clk);
    if (rst_n) begin
      hist.push_back(pat);
      model_edge();
    end
    #1;
    check("digit0", 16'(dif.digit0), 16'(exp_digit[0]));
    check("digit1", 16'(dif.digit1), 16'(exp_digit[1]));
    check("digit2", 16'(dif.digit2), 16'(exp_digit[2]));
    check("digit3", 16'(dif.digit3), 16'(exp_digit[3]));
    check("valid", 16'(dif.valid), 16'(exp_valid));
    check("frame_done", 16'(dif.frame_done), 16'(exp_fd));
    check("decode_error", 16'(dif.decode_error), 16'(exp_de));
    if (dif.frame_done) fd_seen++;
    if (dif.decode_error) de_seen++;
  endtask

  task automatic hold(input logic [11:0] pat, input int cycles);
    for (int i = 0; i < cycles; i++) tick(pat);
  endtask

  initial begin
    int fd0, de0, dur, kind, k, v, frame_k;
    logic [11:0] pat;

    // Reset with digit0/value0 already on the bus
    model_reset();
    rst_n = 1'b0;
    hold({4'b1110, 8'hC0}, 4);
    #1 rst_n = 1'b1;
    hold({4'b1110, 8'hC0}, 18);
    check("rst_valid_e18", 16'(dif.valid), 16'h0);
    tick({4'b1110, 8'hC0});
    check("rst_valid_e19", 16'(dif.valid), 16'h1);

    // Two full frames 3,1,4,9
    for (int f = 0; f < 2; f++) begin
      fd0 = fd_seen;
      hold({4'b1110, 8'hB0}, 40);
      hold({4'b1101, 8'hF9}, 40);
      hold({4'b1011, 8'h99}, 40);
      hold({4'b0111, 8'h98}, 40);
      check("frame_valid", 16'(dif.valid), 16'hF);
      check("frame_digits", {dif.digit3, dif.digit2, dif.digit1, dif.digit0}, 16'h9413);
      check("frame_pulses", 16'(fd_seen - fd0), 16'd1);
    end

    // Glitch shorter than the settle window
    de0 = de_seen;
    hold({4'b1101, 8'hA4}, 10);
    hold(12'hFFF, 30);
    check("glitch_digits", {dif.digit3, dif.digit2, dif.digit1, dif.digit0}, 16'h9413);
    check("glitch_no_err", 16'(de_seen - de0), 16'd0);

    // Illegal cathode on digit2
    de0 = de_seen;
    hold({4'b1011, 8'hFF}, 40);
    check("badcath_err", 16'(de_seen - de0), 16'd1);
    check("badcath_valid", 16'(dif.valid), 16'hB);
    check("badcath_digit2", 16'(dif.digit2), 16'd4);

    // Illegal anode (two digits strobed)
    de0 = de_seen;
    hold({4'b1100, 8'hC0}, 40);
    check("badanode_err", 16'(de_seen - de0), 16'd1);
    check("badanode_valid", 16'(dif.valid), 16'hB);

    // Timeout: long blank, digits hold, next digit0 revalidates
    hold(12'hFFF, TO);
    check("timeout_valid", 16'(dif.valid), 16'h0);
    check("timeout_digits", {dif.digit3, dif.digit2, dif.digit1, dif.digit0}, 16'h9413);
    hold({4'b1110, 8'h92}, 40);
    check("after_timeout_valid", 16'(dif.valid), 16'h1);
    check("after_timeout_digit0", 16'(dif.digit0), 16'd5);

    // Reset in the middle of a frame
    hold({4'b1101, 8'h78}, 25);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_valid", 16'(dif.valid), 16'h0);
    check("midrst_digit0", 16'(dif.digit0), 16'h0);
    hold({4'b1101, 8'h78}, 2);
    #1 rst_n = 1'b1;
    hold({4'b1101, 8'h78}, 30);

    // Randomized segments with boundary durations around the settle window
    frame_k = 0;
    for (int s = 0; s < 300; s++) begin
      kind = $urandom_range(0, 9);
      v    = $urandom_range(0, 9);
      if (kind <= 5) begin
        k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : frame_k;
        frame_k = (frame_k + 1) % 4;
        pat = digit_pat(k, v);
      end else if (kind == 6) begin
        pat = 12'hFFF;
      end else if (kind == 7) begin
        pat = digit_pat($urandom_range(0, 3), v);
        pat[6:0] = 7'($urandom);
        if (seg_val(pat[6:0]) >= 0) pat[6:0] = 7'h7F;
      end else if (kind == 8) begin
        pat = digit_pat(0, v);
        pat[11:8] = 4'($urandom_range(0, 12)) & 4'b1100;
      end else begin
        pat = 12'($urandom);
      end
      case ($urandom_range(0, 3))
        0: dur = $urandom_range(1, S);
        1: dur = S;
        2: dur = S + 1;
        default: dur = $urandom_range(S + 2, 50);
      endcase
      hold(pat, dur);
    end
    hold(12'hFFF, TO + 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
